// File: rtl/brc_hazard_pkg.sv
// Shared types and constants for the ID-stage branch-operand hazard controller.
package brc_hazard_pkg;

  localparam int SB_DEPTH  = 3;
  localparam int SB_REG_W  = 5;
  localparam int SB_DATA_W = 32;

  localparam logic [SB_REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                 vld;
    logic [SB_REG_W-1:0]  rd;
    logic                 rdy;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/brc_sb_match.sv
// Youngest-first scoreboard lookup for one branch source register.
module brc_sb_match
  import brc_hazard_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  sb_entry_t             sb [DEPTH],
  input  logic [SB_REG_W-1:0]   src,
  output logic                  hit,
  output logic                  rdy,
  output logic [SB_DATA_W-1:0]  data
);

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    hit  = 1'b0;
    rdy  = 1'b0;
    data = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (sb[i].vld && sb[i].rd == src && src != REG_ZERO) begin
        hit  = 1'b1;
        rdy  = sb[i].rdy;
        data = sb[i].data;
      end
    end
  end

endmodule

// File: rtl/brc_hazard.sv
// Branch-operand hazard controller: forwards ready producers, stalls otherwise.
// Optional BRC_STALL_CNT_EN adds a free-running stall cycle counter.
module brc_hazard
  import brc_hazard_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int REG_W  = SB_REG_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_is_branch,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_wr_en,
  input  logic [REG_W-1:0]  id_wr_reg,
  input  logic              ex_res_valid,
  input  logic [DATA_W-1:0] ex_res_data,
  input  logic              mem_res_valid,
  input  logic [DATA_W-1:0] mem_res_data,
  input  logic              pipe_hold,
  output logic              forward_rs,
  output logic              forward_rt,
  output logic [DATA_W-1:0] forward_rs_data,
  output logic [DATA_W-1:0] forward_rt_data,
  output logic              brc_stall
`ifdef BRC_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  sb_entry_t sb [DEPTH];
  sb_entry_t head;

  logic              hit_rs, rdy_rs;
  logic              hit_rt, rdy_rt;
  logic [DATA_W-1:0] data_rs, data_rt;
  logic              haz_rs, haz_rt;
  logic              stall;

  brc_sb_match #(.DEPTH(DEPTH)) u_match_rs (
    .sb   (sb),
    .src  (id_rs),
    .hit  (hit_rs),
    .rdy  (rdy_rs),
    .data (data_rs)
  );

  brc_sb_match #(.DEPTH(DEPTH)) u_match_rt (
    .sb   (sb),
    .src  (id_rt),
    .hit  (hit_rt),
    .rdy  (rdy_rt),
    .data (data_rt)
  );

  assign haz_rs = hit_rs & ~rdy_rs;
  assign haz_rt = hit_rt & ~rdy_rt;
  assign stall  = id_valid & id_is_branch & (haz_rs | haz_rt);

  // Stale entries stay visible while rst is high, so mask the outputs.
  assign brc_stall       = ~rst & stall;
  assign forward_rs      = ~rst & hit_rs & rdy_rs;
  assign forward_rt      = ~rst & hit_rt & rdy_rt;
  assign forward_rs_data = forward_rs ? data_rs : '0;
  assign forward_rt_data = forward_rt ? data_rt : '0;

  always_comb begin
    head = '0;
    if (id_valid && id_wr_en && !stall && id_wr_reg != REG_ZERO) begin
      head.vld = 1'b1;
      head.rd  = id_wr_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb[i] <= '0;
      end
    end else if (pipe_hold) begin
      if (ex_res_valid) begin
        sb[0].rdy  <= 1'b1;
        sb[0].data <= ex_res_data;
      end
      if (mem_res_valid) begin
        sb[1].rdy  <= 1'b1;
        sb[1].data <= mem_res_data;
      end
    end else begin
      sb[0] <= head;
      sb[1] <= sb[0];
      if (ex_res_valid) begin
        sb[1].rdy  <= 1'b1;
        sb[1].data <= ex_res_data;
      end
      sb[2] <= sb[1];
      if (mem_res_valid) begin
        sb[2].rdy  <= 1'b1;
        sb[2].data <= mem_res_data;
      end
      for (int i = 3; i < DEPTH; i++) begin
        sb[i] <= sb[i-1];
      end
    end
  end

`ifdef BRC_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (brc_stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  // A writer reaching WB must already carry its value.
  a_wb_ready: assert property (
    @(posedge clk) disable iff (rst)
    !(sb[DEPTH-1].vld && !sb[DEPTH-1].rdy)
  );

endmodule

// File: tb/tb_brc_hazard.sv
// Bench for brc_hazard: directed cycle table plus randomized model check.
module tb_brc_hazard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_is_branch, id_wr_en;
  logic [4:0]  id_rs, id_rt, id_wr_reg;
  logic        ex_res_valid, mem_res_valid, pipe_hold;
  logic [31:0] ex_res_data, mem_res_data;
  logic        forward_rs, forward_rt, brc_stall;
  logic [31:0] forward_rs_data, forward_rt_data;
`ifdef BRC_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  brc_hazard dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_is_branch    (id_is_branch),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_wr_en        (id_wr_en),
    .id_wr_reg       (id_wr_reg),
    .ex_res_valid    (ex_res_valid),
    .ex_res_data     (ex_res_data),
    .mem_res_valid   (mem_res_valid),
    .mem_res_data    (mem_res_data),
    .pipe_hold       (pipe_hold),
    .forward_rs      (forward_rs),
    .forward_rt      (forward_rt),
    .forward_rs_data (forward_rs_data),
    .forward_rt_data (forward_rt_data),
    .brc_stall       (brc_stall)
`ifdef BRC_STALL_CNT_EN
    ,
    .stall_cnt       (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // c = {rst, hold, valid, branch, wr_en}; ef = {fwd_rs, fwd_rt, stall}
  typedef struct {
    logic [4:0]  c;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr;
    logic        exv;
    logic [31:0] exd;
    logic        memv;
    logic [31:0] memd;
    logic [2:0]  ef;
    logic [31:0] eds;
    logic [31:0] edt;
  } vec_t;

  // In-flight writers, youngest at index 0.
  typedef struct {
    logic        v;
    logic [4:0]  r;
    logic        rdy;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  vec_t        tbl[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] cnt_exp = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void model_clear();
    ent_t e;
    e = '{1'b0, 5'd0, 1'b0, 32'd0};
    q.delete();
    repeat (3) q.push_back(e);
  endfunction

  function automatic void look(input logic [4:0] src, output logic hit,
                               output logic rdy, output logic [31:0] d);
    hit = 1'b0;
    rdy = 1'b0;
    d   = '0;
    if (src != 5'd0) begin
      foreach (q[i]) begin
        if (!hit && q[i].v && q[i].r == src) begin
          hit = 1'b1;
          rdy = q[i].rdy;
          d   = q[i].d;
        end
      end
    end
  endfunction

  function automatic logic raw_stall(input vec_t v);
    logic hs, rs_, ht, rt_;
    logic [31:0] ds, dt;
    look(v.rs, hs, rs_, ds);
    look(v.rt, ht, rt_, dt);
    return v.c[2] & v.c[1] & ((hs & !rs_) | (ht & !rt_));
  endfunction

  function automatic void predict(inout vec_t v);
    logic hs, rs_, ht, rt_;
    logic [31:0] ds, dt;
    look(v.rs, hs, rs_, ds);
    look(v.rt, ht, rt_, dt);
    if (v.c[4]) begin
      v.ef  = 3'b000;
      v.eds = '0;
      v.edt = '0;
    end else begin
      v.ef  = {hs & rs_, ht & rt_, raw_stall(v)};
      v.eds = (hs & rs_) ? ds : 32'd0;
      v.edt = (ht & rt_) ? dt : 32'd0;
    end
  endfunction

  function automatic void model_step(input vec_t v);
    ent_t n;
    logic st;
    if (v.c[4]) begin
      model_clear();
      return;
    end
    st = raw_stall(v);
    if (v.exv) begin
      q[0].rdy = 1'b1;
      q[0].d   = v.exd;
    end
    if (v.memv) begin
      q[1].rdy = 1'b1;
      q[1].d   = v.memd;
    end
    if (!v.c[3]) begin
      n = '{1'b0, 5'd0, 1'b0, 32'd0};
      if (v.c[2] && v.c[0] && !st && v.wr != 5'd0) begin
        n.v = 1'b1;
        n.r = v.wr;
      end
      q.push_front(n);
      void'(q.pop_back());
    end
  endfunction

  task automatic run(input vec_t v, input string tag);
    {rst, pipe_hold, id_valid, id_is_branch, id_wr_en} = v.c;
    id_rs         = v.rs;
    id_rt         = v.rt;
    id_wr_reg     = v.wr;
    ex_res_valid  = v.exv;
    ex_res_data   = v.exd;
    mem_res_valid = v.memv;
    mem_res_data  = v.memd;
    @(negedge clk);
    chk({tag, " fwd_rs"}, {31'd0, forward_rs}, {31'd0, v.ef[2]});
    chk({tag, " fwd_rt"}, {31'd0, forward_rt}, {31'd0, v.ef[1]});
    chk({tag, " stall"}, {31'd0, brc_stall}, {31'd0, v.ef[0]});
    chk({tag, " rs_data"}, forward_rs_data, v.eds);
    chk({tag, " rt_data"}, forward_rt_data, v.edt);
`ifdef BRC_STALL_CNT_EN
    chk({tag, " stall_cnt"}, stall_cnt, cnt_exp);
`endif
    @(posedge clk);
    model_step(v);
    if (v.c[4]) cnt_exp = '0;
    else if (v.ef[0]) cnt_exp = cnt_exp + 32'd1;
    #1;
  endtask

  initial begin
    vec_t v;
    logic hold_r;
    rst = 1'b1;
    {pipe_hold, id_valid, id_is_branch, id_wr_en} = 4'b0;
    {id_rs, id_rt, id_wr_reg} = 15'd0;
    {ex_res_valid, mem_res_valid} = 2'b0;
    ex_res_data  = '0;
    mem_res_data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;

    tbl.push_back('{5'b10000, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0});
    tbl.push_back('{5'b00000, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0});
    tbl.push_back('{5'b00101, 5'd0, 5'd0, 5'd5, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0});
    tbl.push_back('{5'b00110, 5'd5, 5'd0, 5'd0, 1'b1, 32'h1234, 1'b0, 32'h0, 3'b001, 32'h0, 32'h0});
    tbl.push_back('{5'b00110, 5'd5, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b100, 32'h1234, 32'h0});
    tbl.push_back('{5'b00000, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0});
    tbl.push_back('{5'b00101, 5'd0, 5'd0, 5'd7, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0});
    tbl.push_back('{5'b00110, 5'd7, 5'd7, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b001, 32'h0, 32'h0});
    tbl.push_back('{5'b00110, 5'd7, 5'd7, 5'd0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 3'b001, 32'h0, 32'h0});
    tbl.push_back('{5'b00110, 5'd7, 5'd7, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b110, 32'hDEADBEEF, 32'hDEADBEEF});
    tbl.push_back('{5'b00101, 5'd0, 5'd0, 5'd3, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0});
    tbl.push_back('{5'b00101, 5'd0, 5'd0, 5'd3, 1'b1, 32'h22, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0});
    tbl.push_back('{5'b00000, 5'd0, 5'd0, 5'd0, 1'b1, 32'h11, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0});
    tbl.push_back('{5'b00110, 5'd3, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b100, 32'h11, 32'h0});
    tbl.push_back('{5'b00110, 5'd0, 5'd3, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b010, 32'h0, 32'h11});
    tbl.push_back('{5'b00101, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0});
    tbl.push_back('{5'b00110, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0});
    tbl.push_back('{5'b00110, 5'd9, 5'd12, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0});
    tbl.push_back('{5'b00101, 5'd0, 5'd0, 5'd4, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0});
    tbl.push_back('{5'b01110, 5'd4, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b001, 32'h0, 32'h0});
    tbl.push_back('{5'b01110, 5'd4, 5'd0, 5'd0, 1'b1, 32'h44, 1'b0, 32'h0, 3'b001, 32'h0, 32'h0});
    tbl.push_back('{5'b01110, 5'd4, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b100, 32'h44, 32'h0});
    tbl.push_back('{5'b00110, 5'd4, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b100, 32'h44, 32'h0});
    tbl.push_back('{5'b00000, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0});
    tbl.push_back('{5'b00000, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0});
    tbl.push_back('{5'b00101, 5'd0, 5'd0, 5'd8, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0});
    tbl.push_back('{5'b00110, 5'd8, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b001, 32'h0, 32'h0});
    tbl.push_back('{5'b10110, 5'd8, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0});
    tbl.push_back('{5'b00110, 5'd8, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0});

    foreach (tbl[i]) run(tbl[i], $sformatf("row%0d", i));

    for (int n = 0; n < 3000; n++) begin
      hold_r = ($urandom_range(0, 3) == 0);
      v.c    = {n == 0 || $urandom_range(0, 99) == 0, hold_r,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1))};
      v.rs   = 5'($urandom_range(0, 7));
      v.rt   = 5'($urandom_range(0, 7));
      v.wr   = 5'($urandom_range(0, 7));
      v.exv  = 1'($urandom_range(0, 1));
      v.exd  = $urandom;
      v.memv = 1'($urandom_range(0, 1));
      v.memd = $urandom;
      // A load must deliver its data before it leaves MEM.
      if (!hold_r && q[1].v && !q[1].rdy) v.memv = 1'b1;
      predict(v);
      run(v, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
